// File: rtl/uart_rx_pkg.sv
// Shared UART definitions used by the receive path (and by the TX parity block).
//   rx_state_e     : receiver FSM state encoding
//   PAR_EVEN/ODD   : PAR_TYP encoding, identical on TX and RX
//   PRESCALE_*     : legal oversampling ratios for the PRESCALE input
package uart_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int unsigned PRESCALE_8  = 8;
    localparam int unsigned PRESCALE_16 = 16;
    localparam int unsigned PRESCALE_32 = 32;

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter and 3-sample majority vote.
//   clk_i         : oversampling clock
//   rst_ni        : synchronous active-low reset
//   rx_i          : serial line
//   en_i          : count while a frame is (or is becoming) active; holds edge_cnt at 0 otherwise
//   prescale_i    : CLK cycles per bit
//   sampled_bit_o : 2-of-3 majority of the mid-bit samples, valid from edge_cnt = PRESCALE/2+2
//   bit_end_o     : high in the last CLK of a bit (edge_cnt = PRESCALE-1)
module uart_rx_sampler #(
    parameter int unsigned PRESC_WIDTH = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   rx_i,
    input  logic                   en_i,
    input  logic [PRESC_WIDTH-1:0] prescale_i,
    output logic                   sampled_bit_o,
    output logic                   bit_end_o
);

    logic [PRESC_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [PRESC_WIDTH-1:0] half;
    logic [2:0]             samples_q, samples_d;
    logic                   last_edge;

    always_comb begin
        half       = prescale_i >> 1;
        last_edge  = (edge_cnt_q == prescale_i - PRESC_WIDTH'(1));
        edge_cnt_d = '0;
        samples_d  = samples_q;
        if (en_i) begin
            edge_cnt_d = last_edge ? '0 : edge_cnt_q + PRESC_WIDTH'(1);
            if (edge_cnt_q == half - PRESC_WIDTH'(1)) samples_d[0] = rx_i;
            if (edge_cnt_q == half)                   samples_d[1] = rx_i;
            if (edge_cnt_q == half + PRESC_WIDTH'(1)) samples_d[2] = rx_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            edge_cnt_q <= '0;
            samples_q  <= 3'b111;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            samples_q  <= samples_d;
        end
    end

    assign sampled_bit_o = (samples_q[0] & samples_q[1]) |
                           (samples_q[0] & samples_q[2]) |
                           (samples_q[1] & samples_q[2]);
    assign bit_end_o     = en_i & last_edge;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, DATA_WIDTH data bits LSB-first, optional parity, stop.
//   CLK        : oversampling clock
//   RST        : synchronous active-low reset
//   RX_IN      : serial line, idle high, already synchronized
//   PAR_EN     : parity bit present
//   PAR_TYP    : 0 even, 1 odd
//   PRESCALE   : CLK cycles per bit (8, 16 or 32)
//   P_DATA     : last error-free byte
//   DATA_VALID : one-cycle pulse, P_DATA just updated
//   PAR_ERR    : one-cycle pulse, parity mismatch
//   STP_ERR    : one-cycle pulse, stop bit sampled 0
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned PRESC_WIDTH = 6
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   RX_IN,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    input  logic [PRESC_WIDTH-1:0] PRESCALE,
    output logic [DATA_WIDTH-1:0]  P_DATA,
    output logic                   DATA_VALID,
    output logic                   PAR_ERR,
    output logic                   STP_ERR
);

    localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    rx_state_e              state_q, state_d;
    logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [DATA_WIDTH-1:0]  p_data_q, p_data_d;
    logic                   par_bad_q, par_bad_d;
    logic                   par_en_q, par_en_d;
    logic                   par_typ_q, par_typ_d;
    logic [PRESC_WIDTH-1:0] prescale_q, prescale_d;
    logic                   data_valid_q, data_valid_d;
    logic                   par_err_q, par_err_d;
    logic                   stp_err_q, stp_err_d;

    logic                   sampled_bit;
    logic                   bit_end;
    logic                   smp_en;
    logic [PRESC_WIDTH-1:0] smp_prescale;

    // The start-detect cycle already counts as edge_cnt = 0, so the sampler runs on the
    // live PRESCALE in that one cycle and on the latched copy for the rest of the frame.
    assign smp_en       = (state_q != StIdle) || !RX_IN;
    assign smp_prescale = (state_q == StIdle) ? PRESCALE : prescale_q;

    uart_rx_sampler #(
        .PRESC_WIDTH (PRESC_WIDTH)
    ) u_sampler (
        .clk_i         (CLK),
        .rst_ni        (RST),
        .rx_i          (RX_IN),
        .en_i          (smp_en),
        .prescale_i    (smp_prescale),
        .sampled_bit_o (sampled_bit),
        .bit_end_o     (bit_end)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        par_bad_d    = par_bad_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        prescale_d   = prescale_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!RX_IN) begin
                    state_d    = StStart;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    prescale_d = PRESCALE;
                    bit_cnt_d  = '0;
                    par_bad_d  = 1'b0;
                end
            end
            StStart: begin
                // A start that reads back high at mid-bit was a glitch.
                if (bit_end) state_d = sampled_bit ? StIdle : StData;
            end
            StData: begin
                if (bit_end) begin
                    shift_d[bit_cnt_q] = sampled_bit;
                    if (bit_cnt_q == CntW'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    par_bad_d = sampled_bit != ((^shift_q) ^ (par_typ_q == PAR_ODD));
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                    if (sampled_bit && !par_bad_q) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end else begin
                        stp_err_d = !sampled_bit;
                        par_err_d = par_bad_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            p_data_q     <= '0;
            par_bad_q    <= 1'b0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            prescale_q   <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            par_bad_q    <= par_bad_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            prescale_q   <= prescale_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign DATA_VALID = data_valid_q;
    assign PAR_ERR    = par_err_q;
    assign STP_ERR    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a vector table of whole frames plus hand-written sequences
// for glitch, back-to-back, break and mid-frame reset.
module tb_uart_rx;
    import uart_rx_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [5:0] PRESCALE = 6'd8;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STP_ERR;

    uart_rx #(
        .DATA_WIDTH  (8),
        .PRESC_WIDTH (6)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .PRESCALE   (PRESCALE),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR)
    );

    always #5 CLK = ~CLK;

    // Free-running pulse monitor, sampled on the falling edge.
    int         cyc = 0;
    int         n_dv = 0;
    int         n_pe = 0;
    int         n_se = 0;
    int         dv_cyc = 0;
    logic [7:0] dv_log [16];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (DATA_VALID) begin
            n_dv   <= n_dv + 1;
            dv_cyc <= cyc;
            if (n_dv < 16) dv_log[n_dv] <= P_DATA;
        end
        if (PAR_ERR) n_pe <= n_pe + 1;
        if (STP_ERR) n_se <= n_se + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; holds v for p clocks, optionally inverting the mid-point sample.
    task automatic drive_bit(input logic v, input int p, input bit corrupt);
        for (int k = 0; k < p; k++) begin
            RX_IN = (corrupt && k == p / 2) ? ~v : v;
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Config is scrambled after the start bit; the DUT must use its latched copy.
    task automatic send_frame(input int presc, input bit pen, input bit ptyp,
                              input logic [7:0] data, input bit par_flip,
                              input bit stop_v, input bit corrupt);
        PRESCALE = 6'(presc);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        drive_bit(1'b0, presc, 1'b0);
        PRESCALE = (presc == 8) ? 6'd32 : 6'd8;
        PAR_EN   = ~pen;
        PAR_TYP  = ~ptyp;
        for (int i = 0; i < 8; i++) drive_bit(data[i], presc, corrupt);
        if (pen) drive_bit((^data) ^ ptyp ^ par_flip, presc, 1'b0);
        drive_bit(stop_v, presc, 1'b0);
        RX_IN = 1'b1;
    endtask

    typedef struct {
        int presc;
        bit pen;
        bit ptyp;
        int data;
        bit par_flip;
        bit stop_v;
        bit corrupt;
        int exp_dv;
        int exp_pe;
        int exp_se;
        int exp_pd;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int s_dv, s_pe, s_se, t0;

        // presc pen ptyp data par_flip stop corrupt | dv pe se p_data
        vecs[0] = '{PRESCALE_8,  0, 0, 'hA5, 0, 1, 0, 1, 0, 0, 'hA5};
        vecs[1] = '{PRESCALE_16, 1, 0, 'h3C, 0, 1, 0, 1, 0, 0, 'h3C};
        vecs[2] = '{PRESCALE_16, 1, 0, 'h3C, 1, 1, 0, 0, 1, 0, 'h3C};
        vecs[3] = '{PRESCALE_32, 1, 1, 'h00, 0, 0, 0, 0, 0, 1, 'h3C};
        vecs[4] = '{PRESCALE_32, 1, 1, 'hFF, 0, 1, 0, 1, 0, 0, 'hFF};
        vecs[5] = '{PRESCALE_8,  0, 0, 'h5A, 0, 1, 1, 1, 0, 0, 'h5A};
        vecs[6] = '{PRESCALE_8,  1, 0, 'h07, 0, 1, 0, 1, 0, 0, 'h07};
        vecs[7] = '{PRESCALE_8,  1, 1, 'h01, 1, 0, 0, 0, 1, 1, 'h07};

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset p_data", int'(P_DATA), 0);
        check("reset data_valid", int'(DATA_VALID), 0);
        check("reset par_err", int'(PAR_ERR), 0);
        check("reset stp_err", int'(STP_ERR), 0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        idle(4);

        // Table of whole frames
        for (int i = 0; i < 8; i++) begin
            s_dv = n_dv;
            s_pe = n_pe;
            s_se = n_se;
            t0   = cyc;
            send_frame(vecs[i].presc, vecs[i].pen, vecs[i].ptyp, 8'(vecs[i].data),
                       vecs[i].par_flip, vecs[i].stop_v, vecs[i].corrupt);
            idle(4);
            check($sformatf("v%0d data_valid", i), n_dv - s_dv, vecs[i].exp_dv);
            check($sformatf("v%0d par_err", i), n_pe - s_pe, vecs[i].exp_pe);
            check($sformatf("v%0d stp_err", i), n_se - s_se, vecs[i].exp_se);
            check($sformatf("v%0d p_data", i), int'(P_DATA), vecs[i].exp_pd);
            // DATA_VALID is seen in the clock period after the (10 or 11)*PRESCALE-th
            // rising edge following the start edge.
            if (vecs[i].exp_dv != 0)
                check($sformatf("v%0d latency", i), dv_cyc - t0,
                      (vecs[i].pen ? 11 : 10) * vecs[i].presc);
        end

        // Back-to-back frames, no idle gap
        s_dv = n_dv;
        send_frame(PRESCALE_16, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1, 1'b0);
        send_frame(PRESCALE_16, 1'b0, 1'b0, 8'h34, 1'b0, 1'b1, 1'b0);
        idle(4);
        check("b2b count", n_dv - s_dv, 2);
        check("b2b first", int'(dv_log[s_dv]), 'h12);
        check("b2b second", int'(dv_log[s_dv + 1]), 'h34);

        // 2-CLK glitch on idle line
        s_dv = n_dv;
        s_pe = n_pe;
        s_se = n_se;
        PRESCALE = 6'd16;
        RX_IN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        idle(40);
        check("glitch pulses", (n_dv - s_dv) + (n_pe - s_pe) + (n_se - s_se), 0);
        s_dv = n_dv;
        send_frame(PRESCALE_16, 1'b0, 1'b0, 8'h6B, 1'b0, 1'b1, 1'b0);
        idle(4);
        check("post-glitch data_valid", n_dv - s_dv, 1);
        check("post-glitch p_data", int'(P_DATA), 'h6B);

        // Break: line low for 250 CLK at PRESCALE=8 gives a stop error every 80 CLK
        s_dv = n_dv;
        s_se = n_se;
        PRESCALE = 6'd8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (250) @(posedge CLK);
        #1;
        check("break stp_err", n_se - s_se, 3);
        check("break data_valid", n_dv - s_dv, 0);
        idle(120);

        // Reset during data bit 4
        s_dv = n_dv;
        s_pe = n_pe;
        s_se = n_se;
        PRESCALE = 6'd8;
        PAR_EN   = 1'b0;
        drive_bit(1'b0, 8, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 8, 1'b0);
        for (int k = 0; k < 4; k++) begin
            RX_IN = 1'b1;
            @(posedge CLK);
            #1;
        end
        RST = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("midreset p_data", int'(P_DATA), 0);
        check("midreset outputs", {29'd0, DATA_VALID, PAR_ERR, STP_ERR}, 0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        idle(20);
        send_frame(PRESCALE_8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0);
        idle(4);
        check("after reset data_valid", n_dv - s_dv, 1);
        check("after reset errors", (n_pe - s_pe) + (n_se - s_se), 0);
        check("after reset p_data", int'(P_DATA), 'h81);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
